// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-way intersection light sequencer.
// Divides clk down to a 1 s tick and cycles NS_GREEN -> NS_YELLOW -> EW_GREEN
// -> EW_YELLOW. It shows the seconds left in the current phase (T..1).
// Optional all-red emergency override: define TRAFFIC_EMERGENCY_EN to add the
// `emergency` input.
module traffic_ctrl #(
    parameter int CLK_DIV  = 50000000,
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 5
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TRAFFIC_EMERGENCY_EN
    input  logic       emergency,
`endif
    input  logic       pause,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [4:0] countdown_time,
    output logic       sec_tick
);

    localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [4:0]    GREEN_LD  = 5'(GREEN_T);
    localparam logic [4:0]    YELLOW_LD = 5'(YELLOW_T);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [4:0]    cnt_nxt;
    logic [2:0]    ns_nxt, ew_nxt;
    logic          tick;

    // Tick qualification and prescaler next value; emergency clears the divider
    // so the resumed phase gets a full second before its next decrement.
    always_comb begin
        presc_nxt = presc;
`ifdef TRAFFIC_EMERGENCY_EN
        tick = !emergency && !pause && (presc == PRESC_MAX);
        if (emergency)
            presc_nxt = '0;
        else if (!pause)
            presc_nxt = (presc == PRESC_MAX) ? '0 : presc + 1'b1;
`else
        tick = !pause && (presc == PRESC_MAX);
        if (!pause)
            presc_nxt = (presc == PRESC_MAX) ? '0 : presc + 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= NS_GREEN;
        else     state <= state_nxt;
    end

    // Next state and countdown: decrement on each tick, advance and reload at 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = countdown_time;
        if (tick) begin
            if (countdown_time > 5'd1) begin
                cnt_nxt = countdown_time - 5'd1;
            end else begin
                case (state)
                    NS_GREEN:  state_nxt = NS_YELLOW;
                    NS_YELLOW: state_nxt = EW_GREEN;
                    EW_GREEN:  state_nxt = EW_YELLOW;
                    default:   state_nxt = NS_GREEN;
                endcase
                cnt_nxt = (state_nxt == NS_GREEN || state_nxt == EW_GREEN) ?
                          GREEN_LD : YELLOW_LD;
            end
        end
    end

    // Lamp decode from the upcoming state so lamps change on the same edge as state.
    always_comb begin
        ns_nxt = LAMP_R;
        ew_nxt = LAMP_R;
        case (state_nxt)
            NS_GREEN:  ns_nxt = LAMP_G;
            NS_YELLOW: ns_nxt = LAMP_Y;
            EW_GREEN:  ew_nxt = LAMP_G;
            default:   ew_nxt = LAMP_Y;
        endcase
`ifdef TRAFFIC_EMERGENCY_EN
        if (emergency) begin
            ns_nxt = LAMP_R;
            ew_nxt = LAMP_R;
        end
`endif
    end

    // Registered datapath and outputs; nothing reaches a port combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc          <= '0;
            countdown_time <= GREEN_LD;
            ns_light       <= LAMP_G;
            ew_light       <= LAMP_R;
            sec_tick       <= 1'b0;
        end else begin
            presc          <= presc_nxt;
            countdown_time <= cnt_nxt;
            ns_light       <= ns_nxt;
            ew_light       <= ew_nxt;
            sec_tick       <= tick;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl (CLK_DIV=4, GREEN_T=3, YELLOW_T=2).
// Every expected tick result is queued up front; the monitor pops one entry
// on each sec_tick pulse and compares countdown and lamps.
module tb_traffic_ctrl;
    localparam int CLK_DIV  = 4;
    localparam int GREEN_T  = 3;
    localparam int YELLOW_T = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
`ifdef TRAFFIC_EMERGENCY_EN
    logic       emergency = 1'b0;
`endif
    logic [2:0] ns_light, ew_light;
    logic [4:0] countdown_time;
    logic       sec_tick;

    int          total = 0;
    int          bad = 0;
    int          tick_cnt = 0;
    bit          sb_en = 1'b0;
    logic [10:0] exp_q[$];

    traffic_ctrl #(.CLK_DIV(CLK_DIV), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T)) dut (
        .clk(clk),
        .rst(rst),
`ifdef TRAFFIC_EMERGENCY_EN
        .emergency(emergency),
`endif
        .pause(pause),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .countdown_time(countdown_time),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    initial begin
        if (GREEN_T < 1 || GREEN_T > 31 || YELLOW_T < 1 || YELLOW_T > 31 || CLK_DIV < 1)
            $fatal(1, "illegal parameter range");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int cd, input logic [2:0] ns, input logic [2:0] ew);
        exp_q.push_back({5'(cd), ns, ew});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ticks 1..10 of a full cycle starting from a fresh NS_GREEN.
    task automatic push_cycle();
        push(2, 3'b001, 3'b100); push(1, 3'b001, 3'b100);
        push(2, 3'b010, 3'b100); push(1, 3'b010, 3'b100);
        push(3, 3'b100, 3'b001); push(2, 3'b100, 3'b001); push(1, 3'b100, 3'b001);
        push(2, 3'b100, 3'b010); push(1, 3'b100, 3'b010);
        push(3, 3'b001, 3'b100);
    endtask

    // Monitor: each sec_tick pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_en && sec_tick) begin
            tick_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick: got cd=%0d ns=%b ew=%b expected no tick (t=%0t)",
                         countdown_time, ns_light, ew_light, $time);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if ({countdown_time, ns_light, ew_light} !== e) begin
                    bad++;
                    $display("FAIL tick_value: got cd=%0d ns=%b ew=%b expected cd=%0d ns=%b ew=%b (t=%0t)",
                             countdown_time, ns_light, ew_light, e[10:6], e[5:3], e[2:0], $time);
                end
            end
        end
    end

    initial begin
        int viol;
        // 1. asynchronous reset taking effect between edges
        step(2);
        rst = 1'b0;
        step(4);
        chk("pre_reset_cd", countdown_time, 2);
        chk("pre_reset_tick", sec_tick, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_ns", ns_light, 3'b001);
        chk("rst_ew", ew_light, 3'b100);
        chk("rst_cd", countdown_time, 3);
        chk("rst_tick", sec_tick, 0);
        @(posedge clk); #1 rst = 1'b0;
        sb_en = 1'b1;

        // 2. one full cycle of 40 clocks
        tick_cnt = 0;
        push_cycle();
        step(40);
        @(negedge clk); #1;
        chk("cycle_q_empty", exp_q.size(), 0);
        chk("cycle_ticks", tick_cnt, 10);
        chk("cycle_end_cd", countdown_time, 3);
        chk("cycle_end_ns", ns_light, 3'b001);

        // 3. pause holds prescaler at 2 and suppresses ticks
        tick_cnt = 0;
        push(2, 3'b001, 3'b100);
        step(6);
        pause = 1'b1;
        step(10);
        chk("pause_cd", countdown_time, 2);
        chk("pause_ticks", tick_cnt, 1);
        pause = 1'b0;
        push(1, 3'b001, 3'b100);
        step(1);
        chk("resume_no_tick", sec_tick, 0);
        step(1);
        chk("resume_tick", sec_tick, 1);
        @(negedge clk); #1;
        chk("pause_q_empty", exp_q.size(), 0);
        chk("resume_cd", countdown_time, 1);

        // 4. reset in the middle of EW_GREEN, then a full cycle again
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push(2, 3'b001, 3'b100); push(1, 3'b001, 3'b100);
        push(2, 3'b010, 3'b100); push(1, 3'b010, 3'b100);
        push(3, 3'b100, 3'b001); push(2, 3'b100, 3'b001);
        step(25);
        chk("mid_ew", ew_light, 3'b001);
        chk("mid_ns", ns_light, 3'b100);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ns", ns_light, 3'b001);
        chk("mid_rst_ew", ew_light, 3'b100);
        chk("mid_rst_cd", countdown_time, 3);
        chk("mid_q_empty", exp_q.size(), 0);
        @(posedge clk); #1 rst = 1'b0;
        push_cycle();
        step(40);
        @(negedge clk); #1;
        chk("cycle2_q_empty", exp_q.size(), 0);
        chk("cycle2_end_cd", countdown_time, 3);

`ifdef TRAFFIC_EMERGENCY_EN
        // 5. emergency during NS_YELLOW
        push(2, 3'b001, 3'b100); push(1, 3'b001, 3'b100); push(2, 3'b010, 3'b100);
        step(14);
        emergency = 1'b1;
        step(1);
        chk("emg_ns", ns_light, 3'b100);
        chk("emg_ew", ew_light, 3'b100);
        step(8);
        chk("emg_hold_ns", ns_light, 3'b100);
        chk("emg_hold_ew", ew_light, 3'b100);
        chk("emg_hold_cd", countdown_time, 2);
        emergency = 1'b0;
        push(1, 3'b010, 3'b100);
        step(1);
        chk("emg_resume_ns", ns_light, 3'b010);
        step(3);
        chk("emg_resume_tick", sec_tick, 1);
        @(negedge clk); #1;
        chk("emg_q_empty", exp_q.size(), 0);
`endif

        // 6. random pause/reset safety sweep
        sb_en = 1'b0;
        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            step(1);
            if ((ns_light != 3'b100 && ew_light != 3'b100) || countdown_time == 5'd0)
                viol++;
        end
        chk("safety_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard timeout so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
